// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the mult/div sequencer:
//   state_t                 - sequencer FSM state encoding
//   OP_MULT / OP_DIV        - operation encoding carried on req_op
//   TIMEOUT_CYCLES_DEFAULT  - default watchdog limit in WAIT cycles
// -----------------------------------------------------------------------------
package muldiv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WAIT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int TIMEOUT_CYCLES_DEFAULT = 64;

endpackage : muldiv_pkg

// File: rtl/muldiv_timeout_cnt.sv
// -----------------------------------------------------------------------------
// muldiv_timeout_cnt
// Watchdog for the WAIT state of muldiv_sequencer. Counts cycles while
// enable is high and flags expiry on the cycle in which the count reaches
// TIMEOUT_CYCLES, i.e. on the TIMEOUT_CYCLES-th enabled cycle.
// Only instantiated when MULDIV_TIMEOUT_EN is defined.
// Ports:
//   clk       in   system clock, rising edge
//   reset_in  in   asynchronous active-low reset
//   clear     in   synchronous clear of the count (held outside WAIT)
//   enable    in   count this cycle
//   expired   out  this enabled cycle is the last one allowed
// -----------------------------------------------------------------------------
module muldiv_timeout_cnt
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_in,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int               CNT_W   = 8;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    // The count holds the number of WAIT cycles already completed, so the
    // limit is hit when the current cycle would make it TIMEOUT_CYCLES.
    assign expired = enable && (r_count == LP_LAST);

endmodule : muldiv_timeout_cnt

// File: rtl/muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Control FSM that launches a multiply or divide, waits for the selected
// unit to finish, then strobes the HI/LO register loads. A divide-by-zero
// report aborts the operation; optionally a watchdog aborts a stuck WAIT.
// All outputs are Moore outputs decoded from the state and the latched op.
//
// Configuration macro: MULDIV_TIMEOUT_EN
//   defined   - watchdog (muldiv_timeout_cnt) built, timeout_exc live
//   undefined - WAIT persists indefinitely, timeout_exc tied to 0
//
// Ports:
//   clk          in   system clock, rising edge
//   reset_in     in   asynchronous active-low reset
//   req_valid    in   request a mult/div operation
//   req_op       in   0=MULT, 1=DIV, sampled with req_valid
//   req_ready    out  idle, request will be accepted
//   mult_init    out  start pulse to multiplier
//   mult_stop    in   multiplier result valid
//   div_init     out  start pulse to divider
//   div_stop     in   divider result valid
//   div_zero     in   divider reports zero divisor
//   high_load    out  HI register load strobe
//   low_load     out  LO register load strobe
//   mux_high     out  HI source select (0=mult, 1=div)
//   mux_low      out  LO source select (0=mult, 1=div)
//   busy         out  any state other than IDLE
//   done         out  HI/LO written pulse
//   div_zero_exc out  divide-by-zero abort pulse
//   timeout_exc  out  watchdog abort pulse
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_in,
    input  logic req_valid,
    input  logic req_op,
    output logic req_ready,
    output logic mult_init,
    input  logic mult_stop,
    output logic div_init,
    input  logic div_stop,
    input  logic div_zero,
    output logic high_load,
    output logic low_load,
    output logic mux_high,
    output logic mux_low,
    output logic busy,
    output logic done,
    output logic div_zero_exc,
    output logic timeout_exc
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("muldiv_sequencer: TIMEOUT_CYCLES must be within 2..255");
    end

    state_t r_state;
    state_t w_next;
    logic   r_op;
    logic   w_sel_stop;
    logic   w_zero;
    logic   w_expired;
    logic   w_err_tmo;

    // Only the stop of the unit that was launched can complete the op.
    assign w_sel_stop = (r_op == OP_DIV) ? div_stop : mult_stop;
    assign w_zero     = (r_op == OP_DIV) && div_zero;

`ifdef MULDIV_TIMEOUT_EN
    logic r_err_tmo;

    muldiv_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk      (clk),
        .reset_in (reset_in),
        .clear    (r_state != ST_WAIT),
        .enable   (r_state == ST_WAIT),
        .expired  (w_expired)
    );

    // Remember why ERR was entered; divide-by-zero outranks the watchdog.
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_err_tmo <= 1'b0;
        end else if (w_next == ST_ERR && r_state != ST_ERR) begin
            r_err_tmo <= !w_zero;
        end
    end

    assign w_err_tmo = r_err_tmo;
`else
    assign w_expired = 1'b0;
    assign w_err_tmo = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            r_state <= ST_IDLE;
            r_op    <= OP_MULT;
        end else begin
            r_state <= w_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_op <= req_op;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (req_valid) w_next = ST_START;
            ST_START: w_next = w_zero ? ST_ERR : ST_WAIT;
            ST_WAIT: begin
                if (w_zero)          w_next = ST_ERR;
                else if (w_sel_stop) w_next = ST_WRITE;
                else if (w_expired)  w_next = ST_ERR;
            end
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready    = 1'b0;
        mult_init    = 1'b0;
        div_init     = 1'b0;
        high_load    = 1'b0;
        low_load     = 1'b0;
        mux_high     = 1'b0;
        mux_low      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        div_zero_exc = 1'b0;
        timeout_exc  = 1'b0;
        if (r_state == ST_IDLE) begin
            req_ready = 1'b1;
        end else begin
            busy     = 1'b1;
            mux_high = r_op;
            mux_low  = r_op;
        end
        case (r_state)
            ST_START: begin
                mult_init = (r_op == OP_MULT);
                div_init  = (r_op == OP_DIV);
            end
            ST_WRITE: begin
                high_load = 1'b1;
                low_load  = 1'b1;
            end
            ST_DONE: done = 1'b1;
            ST_ERR: begin
                div_zero_exc = !w_err_tmo;
                timeout_exc  = w_err_tmo;
            end
            default: ;
        endcase
    end

endmodule : muldiv_sequencer

// File: tb/tb_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// tb_muldiv_sequencer
// Self-checking bench for muldiv_sequencer. Expected outputs come from a
// timeline model: for each operation the bench works out from the stop /
// div_zero stimulus at which cycle the operation writes or aborts, and derives
// the expected output vector of every cycle from that phase. Non-selected
// stops, stray req_valid while busy and div_zero on multiplies are driven
// randomly throughout. Define MULDIV_TIMEOUT_EN to run with the watchdog at 8.
// -----------------------------------------------------------------------------
module tb_muldiv_sequencer;

`ifdef MULDIV_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    localparam int PH_IDLE  = 0;
    localparam int PH_START = 1;
    localparam int PH_WAIT  = 2;
    localparam int PH_WRITE = 3;
    localparam int PH_DONE  = 4;
    localparam int PH_ERR   = 5;

    localparam int K_NONE  = 0;
    localparam int K_WRITE = 1;
    localparam int K_ZERO  = 2;
    localparam int K_TMO   = 3;

    logic clk = 1'b0;
    logic reset_in = 1'b0;
    logic req_valid = 1'b0;
    logic req_op = 1'b0;
    logic mult_stop = 1'b0;
    logic div_stop = 1'b0;
    logic div_zero = 1'b0;
    logic req_ready, mult_init, div_init, high_load, low_load;
    logic mux_high, mux_low, busy, done, div_zero_exc, timeout_exc;

    int total = 0;
    int bad = 0;

    logic [10:0] act;
    assign act = {req_ready, mult_init, div_init, high_load, low_load,
                  mux_high, mux_low, busy, done, div_zero_exc, timeout_exc};

    muldiv_sequencer #(
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .reset_in     (reset_in),
        .req_valid    (req_valid),
        .req_op       (req_op),
        .req_ready    (req_ready),
        .mult_init    (mult_init),
        .mult_stop    (mult_stop),
        .div_init     (div_init),
        .div_stop     (div_stop),
        .div_zero     (div_zero),
        .high_load    (high_load),
        .low_load     (low_load),
        .mux_high     (mux_high),
        .mux_low      (mux_low),
        .busy         (busy),
        .done         (done),
        .div_zero_exc (div_zero_exc),
        .timeout_exc  (timeout_exc)
    );

    always #5 clk = ~clk;

    // Expected output vector for a phase, in the bit order of act.
    function automatic logic [10:0] exp_vec(input int ph, input logic op, input logic tmo);
        logic rdy, mi, di, hl, ll, mh, ml, bz, dn, dz, to;
        rdy = (ph == PH_IDLE);
        bz  = !rdy;
        mh  = bz && op;
        ml  = bz && op;
        mi  = (ph == PH_START) && !op;
        di  = (ph == PH_START) && op;
        hl  = (ph == PH_WRITE);
        ll  = (ph == PH_WRITE);
        dn  = (ph == PH_DONE);
        dz  = (ph == PH_ERR) && !tmo;
        to  = (ph == PH_ERR) && tmo;
        return {rdy, mi, di, hl, ll, mh, ml, bz, dn, dz, to};
    endfunction

    // One operation starting from IDLE. stop_w: WAIT cycle (1-based) in which
    // the selected stop is high, 0 = never. zero_at: -1 none, 0 = in START,
    // n = in WAIT cycle n. Runs until back in IDLE or max_c cycles elapsed.
    task automatic run_op(input logic op, input int stop_w, input int zero_at,
                          input int max_c, input string name);
        int e;
        int kind;
        int last;
        int ph;
        e    = 1000000;
        kind = K_NONE;
        if (op && zero_at == 0) begin
            e = 2; kind = K_ZERO;
        end else if (op && zero_at > 0 && (stop_w == 0 || zero_at <= stop_w)) begin
            e = 2 + zero_at; kind = K_ZERO;
        end else if (stop_w > 0) begin
            e = 2 + stop_w; kind = K_WRITE;
        end
`ifdef MULDIV_TIMEOUT_EN
        if (e > 2 + TMO) begin
            e = 2 + TMO; kind = K_TMO;
        end
`endif
        last = (kind == K_WRITE) ? e + 1 : e;

        total++;
        if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL %s idle_before act=%h exp=%h", name, act, exp_vec(PH_IDLE, 1'b0, 1'b0));
        end
        req_valid = 1'b1;
        req_op    = op;
        @(posedge clk); #1;
        for (int c = 1; c <= last && c <= max_c; c++) begin
            if (c == 1)                             ph = PH_START;
            else if (c < e)                         ph = PH_WAIT;
            else if (c == e)                        ph = (kind == K_WRITE) ? PH_WRITE : PH_ERR;
            else                                    ph = PH_DONE;
            total++;
            if (act !== exp_vec(ph, op, kind == K_TMO)) begin
                bad++;
                $display("FAIL %s cycle=%0d act=%h exp=%h", name, c, act, exp_vec(ph, op, kind == K_TMO));
            end
            req_valid = 1'($urandom_range(0, 1));
            req_op    = 1'($urandom_range(0, 1));
            if (op) begin
                div_stop  = (ph == PH_WAIT || ph == PH_START && c == e) ? (c == 1 + stop_w && stop_w > 0)
                                                                       : 1'($urandom_range(0, 1));
                if (ph == PH_START) div_stop = 1'($urandom_range(0, 1));
                mult_stop = 1'($urandom_range(0, 1));
                div_zero  = (ph == PH_START || ph == PH_WAIT) ? (zero_at >= 0 && c == 1 + zero_at)
                                                             : 1'($urandom_range(0, 1));
            end else begin
                mult_stop = (ph == PH_WAIT) ? (c == 1 + stop_w && stop_w > 0) : 1'($urandom_range(0, 1));
                div_stop  = 1'($urandom_range(0, 1));
                div_zero  = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        div_zero  = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b1;
        mult_stop = 1'b1;
        div_stop  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL reset_hold act=%h exp=%h", act, exp_vec(PH_IDLE, 1'b0, 1'b0));
            end
        end
        req_valid = 1'b0;
        mult_stop = 1'b0;
        div_stop  = 1'b0;
        #2 reset_in = 1'b1;
        @(posedge clk); #1;
        total++;
        if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL reset_release act=%h exp=%h", act, exp_vec(PH_IDLE, 1'b0, 1'b0));
        end
    endtask

    task automatic test_mult();
        // 4*3 with mult_stop five cycles after mult_init (WAIT cycle 5)
        run_op(1'b0, 5, -1, 100, "mult_4x3");
    endtask

    task automatic test_div();
        // 23/7 with div_stop on the third WAIT cycle
        run_op(1'b1, 3, -1, 100, "div_23_7");
    endtask

    task automatic test_div_zero();
        run_op(1'b1, 2, 0, 100, "div_zero_start");
        run_op(1'b1, 4, 2, 100, "div_zero_wait");
        run_op(1'b1, 3, 3, 100, "div_zero_with_stop");
    endtask

    task automatic test_stray_stop();
        // mult_stop is randomly toggled by run_op throughout a DIV
        run_op(1'b1, 6, -1, 100, "div_stray_mult_stop");
        run_op(1'b0, 4, -1, 100, "mult_stray_div_stop");
    endtask

`ifdef MULDIV_TIMEOUT_EN
    task automatic test_timeout();
        run_op(1'b0, 0, -1, 100, "timeout_mult");
        run_op(1'b1, 0, -1, 100, "timeout_div");
        run_op(1'b0, TMO, -1, 100, "stop_on_last_wait");
    endtask
`else
    task automatic test_timeout();
        run_op(1'b0, 0, -1, 80, "no_timeout_wait");
        #2 reset_in = 1'b0;
        #1;
        total++;
        if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL no_timeout_recover act=%h exp=%h", act, exp_vec(PH_IDLE, 1'b0, 1'b0));
        end
        #1 reset_in = 1'b1;
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_reset_mid_wait();
        req_valid = 1'b1;
        req_op    = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++;
        if (act !== exp_vec(PH_WAIT, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL mid_wait_state act=%h exp=%h", act, exp_vec(PH_WAIT, 1'b0, 1'b0));
        end
        #2 reset_in = 1'b0;
        #1;
        total++;
        if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
            bad++;
            $display("FAIL async_reset act=%h exp=%h", act, exp_vec(PH_IDLE, 1'b0, 1'b0));
        end
        mult_stop = 1'b1;
        @(posedge clk); #3;
        reset_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
                bad++;
                $display("FAIL stop_after_reset act=%h exp=%h", act, exp_vec(PH_IDLE, 1'b0, 1'b0));
            end
        end
        mult_stop = 1'b0;
        run_op(1'b1, 1, -1, 100, "accept_after_reset");
    endtask

    task automatic test_back_to_back();
        run_op(1'b0, 1, -1, 100, "b2b_min_latency");
        run_op(1'b1, 1, -1, 100, "b2b_div");
        run_op(1'b1, 0, 0, 100, "b2b_zero");
        run_op(1'b0, 2, -1, 100, "b2b_mult");
    endtask

    task automatic test_random();
        logic op;
        int   sw;
        int   za;
        int   gap;
        for (int n = 0; n < 40; n++) begin
            op = 1'($urandom_range(0, 1));
            sw = $urandom_range(1, 6);
            za = -1;
            if (op && $urandom_range(0, 3) == 0) za = $urandom_range(0, sw);
            run_op(op, sw, za, 100, "random_op");
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                mult_stop = 1'($urandom_range(0, 1));
                div_stop  = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
                total++;
                if (act !== exp_vec(PH_IDLE, 1'b0, 1'b0)) begin
                    bad++;
                    $display("FAIL random_idle_gap act=%h exp=%h", act, exp_vec(PH_IDLE, 1'b0, 1'b0));
                end
            end
            mult_stop = 1'b0;
            div_stop  = 1'b0;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_stray_stop();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_muldiv_sequencer
